// File: rtl/debounce_pkg.sv
// Shared constants and counter-width helpers for the multi-channel debouncer.
package debounce_pkg;

  localparam int DEF_CHANNELS      = 4;
  localparam int DEF_STABLE_CYCLES = 20;
  localparam int DEF_HOLD_CYCLES   = 1000;
  localparam int SYNC_DEPTH        = 2;

  // Stability counter holds STABLE_CYCLES-1 down to 0.
  function automatic int stable_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Hold counter must reach HOLD_CYCLES itself, hence the +1.
  function automatic int hold_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// Bundle of raw inputs and debounced/event outputs, W channels wide.
interface multi_debouncer_if #(
  parameter int W = 1
);
  logic [W-1:0] in;
  logic [W-1:0] level;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] held;
  logic [W-1:0] long_press;

  modport master (output in, input level, rise, fall, held, long_press);
  modport slave  (input in, output level, rise, fall, held, long_press);
endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: stability counter, level/edge pulses and long-press tracking.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input logic               clock,
  input logic               reset,
  multi_debouncer_if.slave  ch
);

  localparam int SW = stable_w(STABLE_CYCLES);
  localparam int HW = hold_w(HOLD_CYCLES);
  localparam logic [SW-1:0] STABLE_LOAD = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES);

  logic          last_q, last_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          held_q, held_d;
  logic          long_press_q, long_press_d;

  always_comb begin
    last_d  = last_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    hold_d  = hold_q;

    // Any change restarts the count; level is only taken once the count drains.
    if (ch.in != last_q) begin
      last_d = ch.in;
      cnt_d  = STABLE_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      level_d = last_q;
    end

    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;

    if (!level_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
    end

    // Gating with level_d lets held drop in the same cycle as fall.
    held_d       = level_d && (hold_d == HOLD_MAX);
    long_press_d = held_d & ~held_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q       <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      hold_q       <= '0;
      held_q       <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      hold_q       <= hold_d;
      held_q       <= held_d;
      long_press_q <= long_press_d;
    end
  end

  assign ch.level      = level_q;
  assign ch.rise       = rise_q;
  assign ch.fall       = fall_q;
  assign ch.held       = held_q;
  assign ch.long_press = long_press_q;

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer top. Define MULTI_DEBOUNCER_SYNC_EN to add a
// two-flop synchroniser in front of every channel (+2 cycles latency).
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] held,
  output logic [CHANNELS-1:0] long_press
);

  logic [CHANNELS-1:0] s;

`ifdef MULTI_DEBOUNCER_SYNC_EN
  logic [CHANNELS-1:0] sync_q [SYNC_DEPTH];
  logic [CHANNELS-1:0] sync_d [SYNC_DEPTH];

  always_comb begin
    sync_d[0] = in;
    for (int i = 1; i < SYNC_DEPTH; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < SYNC_DEPTH; i++) begin
      sync_q[i] <= reset ? '0 : sync_d[i];
    end
  end

  assign s = sync_q[SYNC_DEPTH-1];
`else
  assign s = in;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    multi_debouncer_if #(.W(1)) ch_if ();

    assign ch_if.in      = s[g];
    assign level[g]      = ch_if.level;
    assign rise[g]       = ch_if.rise;
    assign fall[g]       = ch_if.fall;
    assign held[g]       = ch_if.held;
    assign long_press[g] = ch_if.long_press;

    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .ch    (ch_if.slave)
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: per-cycle scoreboard against a run-length model plus directed latency checks.
module tb_multi_debouncer;

  localparam int CH     = 2;
  localparam int STABLE = 4;
  localparam int HOLD   = 10;
  localparam int OW     = 5 * CH;
`ifdef MULTI_DEBOUNCER_SYNC_EN
  localparam int LAT_EXTRA = 2;
`else
  localparam int LAT_EXTRA = 0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multi_debouncer_if #(.W(CH)) bus ();

  multi_debouncer #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (STABLE),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in         (bus.in),
    .level      (bus.level),
    .rise       (bus.rise),
    .fall       (bus.fall),
    .held       (bus.held),
    .long_press (bus.long_press)
  );

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [CH-1:0] got_level, got_rise, got_fall, got_held, got_lp;
  logic [OW-1:0] got_all;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: a value is accepted once it has been sampled on STABLE+1 consecutive edges
  int            run_m  [CH];
  logic          cur_m  [CH];
  logic          lvl_m  [CH];
  int            age_m  [CH];
  logic          held_m [CH];
  logic [CH-1:0] pipe0_m = '0;
  logic [CH-1:0] pipe1_m = '0;

  task automatic model_edge(input logic [CH-1:0] in_v, input logic rst_v);
    logic [CH-1:0] lv, rv, fv, hv, lpv, s_v;
    logic prev_l, prev_h;
    lv = '0; rv = '0; fv = '0; hv = '0; lpv = '0;
    if (LAT_EXTRA != 0) s_v = pipe1_m;
    else                s_v = in_v;
    pipe1_m = rst_v ? '0 : pipe0_m;
    pipe0_m = rst_v ? '0 : in_v;
    for (int c = 0; c < CH; c++) begin
      if (rst_v) begin
        run_m[c] = STABLE + 1; cur_m[c] = 1'b0; lvl_m[c] = 1'b0;
        age_m[c] = 0; held_m[c] = 1'b0;
      end else begin
        prev_l = lvl_m[c];
        prev_h = held_m[c];
        if (s_v[c] == cur_m[c]) run_m[c]++;
        else begin cur_m[c] = s_v[c]; run_m[c] = 1; end
        if (run_m[c] >= STABLE + 1) lvl_m[c] = cur_m[c];
        if (lvl_m[c] && prev_l) age_m[c]++;
        else                    age_m[c] = 0;
        held_m[c] = lvl_m[c] && (age_m[c] >= HOLD);
        lv[c]  = lvl_m[c];
        rv[c]  = lvl_m[c] & ~prev_l;
        fv[c]  = ~lvl_m[c] & prev_l;
        hv[c]  = held_m[c];
        lpv[c] = held_m[c] & ~prev_h;
      end
    end
    exp_q.push_back({lpv, hv, fv, rv, lv});
  endtask

  // driver: one clock per call, scoreboard compared after the edge
  task automatic step(input logic [CH-1:0] in_v, input logic rst_v);
    logic [OW-1:0] e;
    @(negedge clock);
    bus.in = in_v;
    reset  = rst_v;
    model_edge(in_v, rst_v);
    @(posedge clock);
    #1;
    got_level = bus.level; got_rise = bus.rise; got_fall = bus.fall;
    got_held  = bus.held;  got_lp   = bus.long_press;
    got_all   = {got_lp, got_held, got_fall, got_rise, got_level};
    e = exp_q.pop_front();
    check_eq("cycle_outputs", 32'(got_all), 32'(e));
  endtask

  initial begin
    int rise_at, held_at, fall_at, drop_at, lp_cnt, rise_cnt;
    logic [CH-1:0] v;
    bus.in = '0;

    // reset state
    step('0, 1'b1);
    step('0, 1'b1);
    check_eq("reset_outputs", 32'(got_all), 32'd0);
    repeat (3) step('0, 1'b0);

    // ch0 accepted STABLE edges after first sampling edge, ch1 quiet
    rise_at = 0; rise_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step(2'b01, 1'b0);
      if (got_rise[0]) begin rise_cnt++; if (rise_at == 0) rise_at = k; end
      if (got_level[1] | got_rise[1]) check_eq("ch1_quiet", 32'(got_level[1] | got_rise[1]), 32'd0);
    end
    check_eq("rise0_latency", rise_at, 1 + STABLE + LAT_EXTRA);
    check_eq("rise0_single", rise_cnt, 1);
    repeat (10) step(2'b00, 1'b0);
    check_eq("level0_released", 32'(got_level), 32'd0);

    // short glitch rejected
    rise_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step((k < 3) ? 2'b01 : 2'b00, 1'b0);
      rise_cnt += int'(got_rise[0]) + int'(got_level[0]);
    end
    check_eq("glitch_rejected", rise_cnt, 0);

    // ch1 long press, then release
    rise_at = 0; held_at = 0; lp_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      step(2'b10, 1'b0);
      if (got_rise[1] && rise_at == 0) rise_at = k;
      if (got_held[1] && held_at == 0) held_at = k;
      lp_cnt += int'(got_lp[1]);
    end
    check_eq("held_latency", held_at - rise_at, HOLD);
    check_eq("long_press_once", lp_cnt, 1);
    check_eq("held_still_high", 32'(got_held[1]), 32'd1);
    fall_at = 0; drop_at = 0;
    for (int k = 1; k <= 10; k++) begin
      step(2'b00, 1'b0);
      if (got_fall[1] && fall_at == 0) fall_at = k;
      if (!got_held[1] && drop_at == 0) drop_at = k;
    end
    check_eq("fall1_latency", fall_at, 1 + STABLE + LAT_EXTRA);
    check_eq("held_drop_with_fall", drop_at, fall_at);

    // reset mid-debounce discards progress
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    check_eq("mid_reset_outputs", 32'(got_all), 32'd0);
    rise_at = 0;
    for (int k = 1; k <= 10; k++) begin
      step(2'b01, 1'b0);
      if (got_rise[0] && rise_at == 0) rise_at = k;
    end
    check_eq("rise_after_reset", rise_at, 1 + STABLE + LAT_EXTRA);

    // stuck input keeps held high past saturation
    repeat (40) step(2'b11, 1'b0);
    check_eq("stuck_held", 32'(got_held), 32'h3);
    repeat (8) step(2'b00, 1'b0);

    // random bouncing, fast then slow, with occasional resets
    v = '0;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, (k < 250) ? 5 : 24) == 0) v[c] = ~v[c];
      step(v, ($urandom_range(0, 149) == 0));
    end

    check_eq("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
